// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: instruction-fetch sequencer.
// Holds the fetch PC and drives the combinational imem address. Each fetched
// word is buffered with its PC in a small prefetch FIFO. Decode reads the
// FIFO through a valid/ready handshake. Redirects flush the FIFO. A misaligned
// redirect target latches a sticky error and halts fetch until reset.
module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,  // must be 4-byte aligned
  parameter int          DEPTH    = 2               // power of two, >= 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [31:0] imem_a,
  input  logic [31:0] imem_rd,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  output logic        fetch_err
);

  localparam int              AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]     C_FULL    = (AW+1)'(DEPTH);
  localparam logic [AW:0]     C_CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0]   C_PTR_ONE = AW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic [31:0]   r_fetch_pc;
  logic          r_err;

  logic [31:0]   r_mem_pc    [DEPTH];
  logic [31:0]   r_mem_instr [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [AW:0]   r_count;

  logic          w_valid;
  logic          w_full;
  logic          w_misalign;
  logic          w_redir_ok;
  logic          w_flush;
  logic          w_pop;
  logic          w_push;

  // Status derived purely from registered occupancy; no path from instr_ready.
  assign w_valid = (r_count != '0);
  assign w_full  = (r_count == C_FULL);

  // Next-state and per-cycle FIFO/PC control decisions.
  always_comb begin
    w_state_nxt = r_state;
    w_misalign  = 1'b0;
    w_redir_ok  = 1'b0;
    w_flush     = 1'b0;
    w_pop       = 1'b0;
    w_push      = 1'b0;

    // A misaligned target is an error from any state, including HALT.
    w_misalign = redirect_valid && (redirect_pc[1:0] != 2'b00);
    // Aligned redirects are honoured everywhere except HALT.
    w_redir_ok = redirect_valid && !w_misalign && (r_state != S_HALT);
    w_flush    = w_misalign || w_redir_ok;

    // Any redirect wins over the handshake: the head is not consumed.
    w_pop  = w_valid && instr_ready && !redirect_valid;
    // Fetch only in FETCH; a full FIFO still accepts when the head leaves.
    w_push = (r_state == S_FETCH) && !redirect_valid && (!w_full || w_pop);

    unique case (r_state)
      S_IDLE: begin
        if (en) w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        // A redirect keeps the sequencer in FETCH even with en low.
        if (!en && !redirect_valid) w_state_nxt = S_IDLE;
      end
      S_HALT: begin
        w_state_nxt = S_HALT;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (w_misalign) w_state_nxt = S_HALT;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Fetch PC: redirect target, else sequential advance on each push (wraps mod 2^32).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_PC;
    end else if (w_redir_ok) begin
      r_fetch_pc <= redirect_pc;
    end else if (w_push) begin
      r_fetch_pc <= r_fetch_pc + 32'd4;
    end
  end

  // Sticky misaligned-redirect flag; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_misalign) begin
      r_err <= 1'b1;
    end
  end

  // FIFO storage: capture {PC, instruction} at the tail on each push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_pc[i]    <= 32'h0;
        r_mem_instr[i] <= 32'h0;
      end
    end else if (w_push) begin
      r_mem_pc[r_wr_ptr]    <= r_fetch_pc;
      r_mem_instr[r_wr_ptr] <= imem_rd;
    end
  end

  // FIFO pointers and occupancy; a flush empties the FIFO outright.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (w_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + C_CNT_ONE;
        2'b01:   r_count <= r_count - C_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  assign imem_a      = r_fetch_pc;
  assign instr_valid = w_valid;
  assign instr       = r_mem_instr[r_rd_ptr];
  assign instr_pc    = r_mem_pc[r_rd_ptr];
  assign fetch_err   = r_err;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Testbench for imem_fetch_ctrl: table-driven cycle trace plus hand-written
// sequences for reset values, asynchronous reset and PC wrap-around.
module tb_imem_fetch_ctrl;

  localparam logic [31:0] I0 = 32'h0050_0113;
  localparam logic [31:0] I1 = 32'h00c0_0193;
  localparam logic [31:0] I2 = 32'h01e0_0113;
  localparam logic [31:0] I3 = 32'h0220_2423;
  localparam logic [31:0] W10 = 32'hD000_0010;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [31:0] imem_a;
  logic [31:0] imem_rd;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b0;
  logic        fetch_err;

  logic        en2 = 1'b0;
  logic [31:0] imem_a2;
  logic [31:0] imem_rd2;
  logic        rv2 = 1'b0;
  logic [31:0] rpc2 = 32'h0;
  logic        valid2;
  logic [31:0] instr2;
  logic [31:0] pc2;
  logic        ready2 = 1'b0;
  logic        err2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    case (a)
      32'h0:   return I0;
      32'h4:   return I1;
      32'h8:   return I2;
      32'hC:   return I3;
      default: return 32'hD000_0000 ^ a;
    endcase
  endfunction

  assign imem_rd  = imem_word(imem_a);
  assign imem_rd2 = ~imem_a2;

  imem_fetch_ctrl #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .imem_a(imem_a), .imem_rd(imem_rd),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .fetch_err(fetch_err)
  );

  imem_fetch_ctrl #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .en(en2), .imem_a(imem_a2), .imem_rd(imem_rd2),
    .redirect_valid(rv2), .redirect_pc(rpc2),
    .instr_valid(valid2), .instr(instr2), .instr_pc(pc2),
    .instr_ready(ready2), .fetch_err(err2)
  );

  typedef struct {
    bit          rst;
    bit          en;
    bit          rdy;
    bit          rv;
    logic [31:0] rpc;
    bit          ev;
    logic [31:0] epc;
    logic [31:0] ei;
    logic [31:0] ea;
    bit          eerr;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic add(input bit rst, input bit e, input bit rdy, input bit rv,
                     input logic [31:0] rpc, input bit ev, input logic [31:0] epc,
                     input logic [31:0] ei, input logic [31:0] ea, input bit eerr);
    vecs.push_back('{rst, e, rdy, rv, rpc, ev, epc, ei, ea, eerr});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    en2 = 1'b0; ready2 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] exp_a2  [5];
  bit          exp_v2  [5];
  logic [31:0] exp_pc2 [5];

  initial begin
    // Segment 1: streaming with ready held high.
    add(1,1,1,0,32'h0,  0,32'h0,32'h0, 32'h0, 0);
    add(0,1,1,0,32'h0,  0,32'h0,32'h0, 32'h0, 0);
    add(0,1,1,0,32'h0,  1,32'h0,I0,    32'h4, 0);
    add(0,1,1,0,32'h0,  1,32'h4,I1,    32'h8, 0);
    add(0,1,1,0,32'h0,  1,32'h8,I2,    32'hC, 0);
    add(0,1,1,0,32'h0,  1,32'hC,I3,    32'h10,0);
    // Segment 2: backpressure, resume, aligned redirect, en=0 drain, IDLE redirect.
    add(1,1,0,0,32'h0,  0,32'h0,32'h0, 32'h0, 0);
    add(0,1,0,0,32'h0,  0,32'h0,32'h0, 32'h0, 0);
    add(0,1,0,0,32'h0,  1,32'h0,I0,    32'h4, 0);
    add(0,1,0,0,32'h0,  1,32'h0,I0,    32'h8, 0);
    add(0,1,0,0,32'h0,  1,32'h0,I0,    32'h8, 0);
    add(0,1,0,0,32'h0,  1,32'h0,I0,    32'h8, 0);
    add(0,1,1,0,32'h0,  1,32'h0,I0,    32'h8, 0);
    add(0,1,1,0,32'h0,  1,32'h4,I1,    32'hC, 0);
    add(0,1,1,0,32'h0,  1,32'h8,I2,    32'h10,0);
    add(0,1,1,1,32'h8,  1,32'hC,I3,    32'h14,0);
    add(0,1,1,0,32'h0,  0,32'h0,32'h0, 32'h8, 0);
    add(0,1,1,0,32'h0,  1,32'h8,I2,    32'hC, 0);
    add(0,1,0,0,32'h0,  1,32'hC,I3,    32'h10,0);
    add(0,0,0,0,32'h0,  1,32'hC,I3,    32'h14,0);
    add(0,0,1,0,32'h0,  1,32'hC,I3,    32'h14,0);
    add(0,0,1,0,32'h0,  1,32'h10,W10,  32'h14,0);
    add(0,0,1,0,32'h0,  0,32'h0,32'h0, 32'h14,0);
    add(0,0,1,1,32'h40, 0,32'h0,32'h0, 32'h14,0);
    add(0,0,1,0,32'h0,  0,32'h0,32'h0, 32'h40,0);
    // Segment 3: misaligned redirect halts; only reset recovers.
    add(1,1,0,0,32'h0,  0,32'h0,32'h0, 32'h0, 0);
    add(0,1,0,0,32'h0,  0,32'h0,32'h0, 32'h0, 0);
    add(0,1,0,0,32'h0,  1,32'h0,I0,    32'h4, 0);
    add(0,1,0,1,32'h6,  1,32'h0,I0,    32'h8, 0);
    add(0,1,1,0,32'h0,  0,32'h0,32'h0, 32'h8, 1);
    add(0,1,1,1,32'h20, 0,32'h0,32'h0, 32'h8, 1);
    add(0,0,1,0,32'h0,  0,32'h0,32'h0, 32'h8, 1);
    add(0,1,1,0,32'h0,  0,32'h0,32'h0, 32'h8, 1);
    add(0,1,1,0,32'h0,  0,32'h0,32'h0, 32'h8, 1);
    add(1,0,1,0,32'h0,  0,32'h0,32'h0, 32'h0, 0);

    // Reset values while rst_n is held low.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid",  {31'h0, instr_valid}, 32'h0);
    chk("rst_instr",  instr,    32'h0);
    chk("rst_pc",     instr_pc, 32'h0);
    chk("rst_imem_a", imem_a,   32'h0);
    chk("rst_err",    {31'h0, fetch_err}, 32'h0);
    chk("rst_imem_a2", imem_a2, 32'hFFFF_FFF8);
    rst_n = 1'b1;

    // Table-driven trace: inputs for the cycle, expected registered outputs in it.
    foreach (vecs[k]) begin
      if (vecs[k].rst) do_reset();
      en             = vecs[k].en;
      instr_ready    = vecs[k].rdy;
      redirect_valid = vecs[k].rv;
      redirect_pc    = vecs[k].rpc;
      chk($sformatf("v%0d_valid", k), {31'h0, instr_valid}, {31'h0, vecs[k].ev});
      chk($sformatf("v%0d_imem_a", k), imem_a, vecs[k].ea);
      chk($sformatf("v%0d_err", k), {31'h0, fetch_err}, {31'h0, vecs[k].eerr});
      if (vecs[k].ev) begin
        chk($sformatf("v%0d_pc", k), instr_pc, vecs[k].epc);
        chk($sformatf("v%0d_instr", k), instr, vecs[k].ei);
      end
      step();
    end

    // Asynchronous reset in the middle of streaming.
    do_reset();
    en = 1'b1; instr_ready = 1'b1;
    repeat (4) step();
    chk("mid_valid_before", {31'h0, instr_valid}, 32'h1);
    chk("mid_pc_before", instr_pc, 32'h8);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid",  {31'h0, instr_valid}, 32'h0);
    chk("mid_rst_instr",  instr,    32'h0);
    chk("mid_rst_pc",     instr_pc, 32'h0);
    chk("mid_rst_imem_a", imem_a,   32'h0);
    chk("mid_rst_err",    {31'h0, fetch_err}, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    en = 1'b0; instr_ready = 1'b0;

    // PC wrap-around from RESET_PC = 0xFFFF_FFF8.
    exp_a2  = '{32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    exp_v2  = '{0, 0, 1, 1, 1};
    exp_pc2 = '{32'h0, 32'h0, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    do_reset();
    en2 = 1'b1; ready2 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("wrap%0d_imem_a", k), imem_a2, exp_a2[k]);
      chk($sformatf("wrap%0d_valid", k), {31'h0, valid2}, {31'h0, exp_v2[k]});
      if (exp_v2[k]) begin
        chk($sformatf("wrap%0d_pc", k), pc2, exp_pc2[k]);
        chk($sformatf("wrap%0d_instr", k), instr2, ~exp_pc2[k]);
      end
      step();
    end
    en2 = 1'b0; ready2 = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
